// File: rtl/key_event_if.sv
// Key event bus: debounced key strobe/level in, classified one-cycle events out.
interface key_event_if;
  logic       key_flag;
  logic       key_state;
  logic       short_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       double_pulse;
  logic       busy;
  logic [7:0] evt_cnt;

  modport master (
    output key_flag, key_state,
    input  short_pulse, long_pulse, repeat_pulse, double_pulse, busy, evt_cnt
  );

  modport slave (
    input  key_flag, key_state,
    output short_pulse, long_pulse, repeat_pulse, double_pulse, busy, evt_cnt
  );
endinterface

// File: rtl/key_event_ctrl.sv
// Classifies debounced key gestures into short, long, auto-repeat and double-click
// one-cycle events, with a running 8-bit count of emitted events.
module key_event_ctrl #(
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned REPEAT_CNT = 10_000_000,
  parameter int unsigned DCLICK_CNT = 15_000_000,
  parameter bit          DCLICK_EN  = 1'b1,
  parameter int unsigned CNT_W      = 26
) (
  input logic        clk,
  input logic        reset,
  key_event_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_HOLD   = 3'd2,
    S_WAIT2  = 3'd3,
    S_PRESS2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_END = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_END = CNT_W'(DCLICK_CNT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_double;
  logic             r_busy;
  logic [7:0]       r_evt_cnt;

  logic w_press;
  logic w_release;

  assign w_press   = bus.key_flag & ~bus.key_state;
  assign w_release = bus.key_flag &  bus.key_state;

  // Release beats a terminal count in PRESS1/HOLD, press beats timeout in WAIT2:
  // the strobe branch is tested first in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_double  <= 1'b0;
      r_busy    <= 1'b0;
      r_evt_cnt <= '0;
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_busy <= w_press;
          if (w_press) r_state <= S_PRESS1;
        end
        S_PRESS1: begin
          if (w_release) begin
            r_cnt <= '0;
            if (DCLICK_EN) begin
              r_state <= S_WAIT2;
            end else begin
              r_state   <= S_IDLE;
              r_short   <= 1'b1;
              r_busy    <= 1'b0;
              r_evt_cnt <= r_evt_cnt + 8'd1;
            end
          end else if (r_cnt == LONG_END) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_long    <= 1'b1;
            r_evt_cnt <= r_evt_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_release) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == REPEAT_END) begin
            r_cnt     <= '0;
            r_repeat  <= 1'b1;
            r_evt_cnt <= r_evt_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT2: begin
          if (w_press) begin
            r_state <= S_PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == DCLICK_END) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_short   <= 1'b1;
            r_busy    <= 1'b0;
            r_evt_cnt <= r_evt_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRESS2: begin
          r_cnt <= '0;
          if (w_release) begin
            r_state   <= S_IDLE;
            r_double  <= 1'b1;
            r_busy    <= 1'b0;
            r_evt_cnt <= r_evt_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.short_pulse  = r_short;
  assign bus.long_pulse   = r_long;
  assign bus.repeat_pulse = r_repeat;
  assign bus.double_pulse = r_double;
  assign bus.busy         = r_busy;
  assign bus.evt_cnt      = r_evt_cnt;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Drives one shared key stream into a double-click-enabled and a double-click-disabled
// controller and checks both against a timestamp-based gesture model every cycle.
module tb_key_event_ctrl;

  localparam int LONG = 20;
  localparam int REP  = 8;
  localparam int DCL  = 10;

  logic clk;
  logic rst_n;

  key_event_if if0 ();
  key_event_if if1 ();

  key_event_ctrl #(
    .LONG_CNT(LONG), .REPEAT_CNT(REP), .DCLICK_CNT(DCL), .DCLICK_EN(1'b1), .CNT_W(5)
  ) u0 (
    .clk(clk), .reset(rst_n), .bus(if0)
  );

  key_event_ctrl #(
    .LONG_CNT(LONG), .REPEAT_CNT(REP), .DCLICK_CNT(DCL), .DCLICK_EN(1'b0), .CNT_W(5)
  ) u1 (
    .clk(clk), .reset(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  // Gesture model: times of first press / first release / long event, click count.
  bit m_en     [2] = '{1'b1, 1'b0};
  bit m_active [2];
  bit m_down   [2];
  int m_clicks [2];
  int m_tp     [2];
  int m_tr     [2];
  int m_tlong  [2];
  bit m_s [2], m_l [2], m_rp [2], m_d [2];
  int m_evt [2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_down[i] = 0; m_clicks[i] = 0; m_tlong[i] = -1;
      m_s[i] = 0; m_l[i] = 0; m_rp[i] = 0; m_d[i] = 0; m_evt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit kf, input bit ks);
    bit p, r;
    p = kf & ~ks;
    r = kf & ks;
    m_s[i] = 0; m_l[i] = 0; m_rp[i] = 0; m_d[i] = 0;
    if (!m_active[i]) begin
      if (p) begin
        m_active[i] = 1; m_down[i] = 1; m_clicks[i] = 1; m_tp[i] = t; m_tlong[i] = -1;
      end
    end else if (m_tlong[i] >= 0) begin
      if (r) m_active[i] = 0;
      else if ((t - m_tlong[i]) % REP == 0) m_rp[i] = 1;
    end else if (m_clicks[i] == 1 && m_down[i]) begin
      if (r) begin
        if (m_en[i]) begin
          m_down[i] = 0; m_tr[i] = t;
        end else begin
          m_s[i] = 1; m_active[i] = 0;
        end
      end else if (t - m_tp[i] == LONG) begin
        m_l[i] = 1; m_tlong[i] = t;
      end
    end else if (m_clicks[i] == 1) begin
      if (p) begin
        m_clicks[i] = 2; m_down[i] = 1;
      end else if (t - m_tr[i] == DCL) begin
        m_s[i] = 1; m_active[i] = 0;
      end
    end else begin
      if (r) begin
        m_d[i] = 1; m_active[i] = 0;
      end
    end
    if (m_s[i] | m_l[i] | m_rp[i] | m_d[i]) m_evt[i] = (m_evt[i] + 1) % 256;
  endtask

  task automatic cmp_dut(input int i, input logic s, input logic l, input logic rp,
                         input logic d, input logic b, input logic [7:0] e);
    check($sformatf("u%0d.short", i),  int'(s),  int'(m_s[i]));
    check($sformatf("u%0d.long", i),   int'(l),  int'(m_l[i]));
    check($sformatf("u%0d.repeat", i), int'(rp), int'(m_rp[i]));
    check($sformatf("u%0d.double", i), int'(d),  int'(m_d[i]));
    check($sformatf("u%0d.busy", i),   int'(b),  int'(m_active[i]));
    check($sformatf("u%0d.evt_cnt", i), int'(e), m_evt[i]);
  endtask

  // One clock: apply inputs, step the model on the sampling edge, compare both DUTs.
  task automatic cycle(input bit kf, input bit ks);
    if0.key_flag = kf; if0.key_state = ks;
    if1.key_flag = kf; if1.key_state = ks;
    @(posedge clk);
    #1;
    t++;
    model_step(0, kf, ks);
    model_step(1, kf, ks);
    cmp_dut(0, if0.short_pulse, if0.long_pulse, if0.repeat_pulse, if0.double_pulse,
            if0.busy, if0.evt_cnt);
    cmp_dut(1, if1.short_pulse, if1.long_pulse, if1.repeat_pulse, if1.double_pulse,
            if1.busy, if1.evt_cnt);
    if0.key_flag = 1'b0;
    if1.key_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic strobe(input bit lvl);
    cycle(1'b1, lvl);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.u0_pulses", int'({if0.short_pulse, if0.long_pulse, if0.repeat_pulse,
                                 if0.double_pulse}), 0);
    check("rst.u0_busy", int'(if0.busy), 0);
    check("rst.u0_evt", int'(if0.evt_cnt), 0);
    check("rst.u1_busy", int'(if1.busy), 0);
    check("rst.u1_evt", int'(if1.evt_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit lvl;
    int gap;
    int gaps [9] = '{6, 7, 8, 9, 10, 18, 19, 20, 21};
    if0.key_flag = 1'b0; if0.key_state = 1'b1;
    if1.key_flag = 1'b0; if1.key_state = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Short press: u0 fires 10 cycles after release, u1 on the release edge.
    strobe(1'b0); idle(4); strobe(1'b1);
    check("t1.u1_short_at_release", int'(if1.short_pulse), 1);
    idle(9);
    check("t1.u0_quiet_before", int'(if0.short_pulse), 0);
    idle(1);
    check("t1.u0_short", int'(if0.short_pulse), 1);
    check("t1.u0_evt", int'(if0.evt_cnt), 1);
    idle(1);
    check("t1.u0_busy_low", int'(if0.busy), 0);

    // Long press with repeats, silent release.
    do_reset();
    strobe(1'b0); idle(19); idle(1);
    check("t2.long", int'(if0.long_pulse), 1);
    idle(7); idle(1);
    check("t2.repeat1", int'(if0.repeat_pulse), 1);
    idle(7); idle(1);
    check("t2.repeat2", int'(if0.repeat_pulse), 1);
    idle(6); strobe(1'b1);
    check("t2.release_quiet", int'(if0.repeat_pulse | if0.short_pulse), 0);
    check("t2.evt", int'(if0.evt_cnt), 3);

    // Double click.
    do_reset();
    strobe(1'b0); idle(2); strobe(1'b1); idle(3); strobe(1'b0); idle(1); strobe(1'b1);
    check("t3.double", int'(if0.double_pulse), 1);
    check("t3.evt", int'(if0.evt_cnt), 1);
    check("t3.u1_evt", int'(if1.evt_cnt), 2);
    idle(12);

    // Release on the long terminal cycle, then press on the double-click timeout cycle.
    strobe(1'b0); idle(19); strobe(1'b1);
    check("t4.no_long", int'(if0.long_pulse), 0);
    idle(9); idle(1);
    check("t4.short_after", int'(if0.short_pulse), 1);
    strobe(1'b0); idle(4); strobe(1'b1); idle(9); strobe(1'b0);
    check("t4.no_short", int'(if0.short_pulse), 0);
    check("t4.busy", int'(if0.busy), 1);
    idle(2); strobe(1'b1);
    check("t4.double", int'(if0.double_pulse), 1);
    idle(12);

    // Spurious second press does not disturb the long timeline.
    strobe(1'b0); idle(3); strobe(1'b0); idle(15); idle(1);
    check("t5.long_u0", int'(if0.long_pulse), 1);
    check("t5.long_u1", int'(if1.long_pulse), 1);
    idle(3);

    // Reset in HOLD, then evt_cnt wrap on the double-click-disabled instance.
    do_reset();
    idle(3);
    check("t6.busy_after_reset", int'(if0.busy), 0);
    for (int k = 0; k < 256; k++) begin
      strobe(1'b0); idle(1); strobe(1'b1); idle(1);
    end
    check("t6.wrap", int'(if1.evt_cnt), 0);
    idle(12);

    // Randomized gestures with boundary-heavy gaps and occasional reset.
    lvl = 1'b1;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        lvl = 1'b1;
      end
      gap = ($urandom_range(0, 2) == 0) ? gaps[$urandom_range(0, 8)] : int'($urandom_range(0, 12));
      idle(gap);
      if ($urandom_range(0, 99) < 85) lvl = ~lvl;
      strobe(lvl);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
